mux4_scan_sequencer: RTL and testbench
======================================

MUX4_SCAN_SEQUENCER -- requirements
Module: mux4_scan_sequencer

Interface
REQ-001 Parameter DWELL, default 4, SHALL set clock cycles per channel; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  SHALL begin one scan frame when sampled high in IDLE.
REQ-005 continuous  input  1  SHALL, when high at frame end, make the next frame start immediately.
REQ-006 mux_in  input  1  SHALL carry the selected bit returned by the downstream 4-to-1 multiplexer.
REQ-007 sel  output  2  SHALL be the channel select driven to the multiplexer.
REQ-008 busy  output  1  SHALL be high while a frame is in progress.
REQ-009 data_out  output  4  SHALL hold the last completed frame; bit k = sample of channel k.
REQ-010 data_valid  output  1  SHALL be a one-cycle pulse marking a data_out update.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-012 IDLE: sel=0, busy=0, dwell counter=0; start=1 at an edge SHALL move to SCAN with sel=0, busy=1, counter=0.
REQ-013 SCAN: the dwell counter SHALL increment every cycle from 0 to DWELL-1; sel SHALL be held stable through the whole dwell.
REQ-014 At the edge where counter==DWELL-1, mux_in SHALL be captured into internal sample bit [sel], the counter SHALL clear, and sel SHALL increment.
REQ-015 At the capture edge for sel==3, data_out SHALL load all four sample bits (channel 3 taken from mux_in at that edge), and data_valid SHALL be 1 for the following cycle only.
REQ-016 Latency: with start accepted at edge E0, channel k SHALL be sampled at edge E0+(k+1)*DWELL, and data_valid SHALL be high in the cycle after edge E0+4*DWELL.
REQ-017 At frame end, if continuous=1 the FSM SHALL remain in SCAN with sel wrapping 3->0, busy staying 1, and no idle gap; if continuous=0 it SHALL return to IDLE (sel=0, busy=0).
REQ-018 continuous SHALL be sampled only at the frame-end edge; toggling it mid-frame SHALL have no effect on the current frame.
REQ-019 start SHALL be ignored while in SCAN, including on the frame-end edge.
REQ-020 data_out SHALL hold its value between data_valid pulses and SHALL never show a partially updated frame.
REQ-021 With DWELL=1, sel SHALL advance every cycle, and a frame SHALL take 4 cycles.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, sel=0, busy=0, data_out=0, data_valid=0, and clear the dwell counter and sample bits.
REQ-023 rst SHALL take priority over start and over any capture on the same edge.
REQ-024 rst during SCAN SHALL abort the frame with no data_valid pulse; the partial samples SHALL be discarded.
REQ-025 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-026 Mux model inputs 4'b0101 (bit0=1, bit1=0, bit2=1, bit3=0), DWELL=4, one start pulse, continuous=0 -> sel sequence 0,1,2,3 with 4 cycles each; data_out=4'b0101; data_valid high exactly 16 cycles after the start edge; busy=0 afterwards.
REQ-027 continuous=1, inputs changed from 4'b0101 to 4'b1010 during frame 2 before channel 0 is sampled -> frame 1 gives 4'b0101, frame 2 gives 4'b1010; valid pulses 16 cycles apart; no idle gap in sel.
REQ-028 start pulsed again at cycles 5 and 16 of a frame -> ignored; exactly one frame and one data_valid pulse.
REQ-029 rst asserted at cycle 10 of a frame -> next cycle shows sel=0, busy=0, data_out=0; no data_valid pulse; a new start then gives a normal frame.
REQ-030 DWELL=1, inputs 4'b1100 -> sel changes every cycle; data_out=4'b1100 with valid 4 cycles after the start edge.
REQ-031 start and rst high on the same edge -> block remains IDLE, busy=0.

Source files
------------

// File: rtl/mux4_scan_sequencer_if.sv
// Handshake bundle between the scan sequencer and its 4:1 mux.
// Ports: start/continuous/mux_in in; sel/busy/data_out/data_valid out.
interface mux4_scan_sequencer_if;
  logic       start;
  logic       continuous;
  logic       mux_in;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] data_out;
  logic       data_valid;

  modport master (
    output start, continuous, mux_in,
    input  sel, busy, data_out, data_valid
  );

  modport slave (
    input  start, continuous, mux_in,
    output sel, busy, data_out, data_valid
  );
endinterface

// File: rtl/mux4_scan_sequencer.sv
// Scans a 4:1 mux channel by channel, DWELL cycles each, and publishes
// a 4-bit frame. Ports: clk, rst (sync, active-high), bus (slave side).
module mux4_scan_sequencer #(
  parameter int DWELL = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux4_scan_sequencer_if.slave bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] samp;
  logic [3:0] dout;
  logic       dv;
  logic [3:0] nxt;

  // Sample set including the bit captured this edge, so the
  // channel-3 edge can publish a complete frame in one step.
  always_comb begin
    nxt      = samp;
    nxt[sel] = bus.mux_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      samp  <= '0;
      dout  <= '0;
      dv    <= 1'b0;
    end else begin
      dv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= SCAN;
            busy  <= 1'b1;
            sel   <= '0;
            cnt   <= '0;
          end
        end
        SCAN: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            samp <= nxt;
            sel  <= sel + 2'd1;
            if (sel == 2'd3) begin
              dout <= nxt;
              dv   <= 1'b1;
              if (!bus.continuous) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel;
  assign bus.busy       = busy;
  assign bus.data_out   = dout;
  assign bus.data_valid = dv;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer: DWELL=4 and DWELL=1 instances share
// stimulus; a frame-timing model is checked every cycle.
module tb_mux4_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] chans = 4'b0101;
  bit         en = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux4_scan_sequencer_if b0 ();
  mux4_scan_sequencer_if b1 ();

  assign b0.start      = start;
  assign b0.continuous = cont;
  assign b0.mux_in     = chans[b0.sel];
  assign b1.start      = start;
  assign b1.continuous = cont;
  assign b1.mux_in     = chans[b1.sel];

  mux4_scan_sequencer #(.DWELL(4)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  mux4_scan_sequencer #(.DWELL(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  logic [1:0] asel[2];
  logic       abusy[2];
  logic [3:0] ado[2];
  logic       adv[2];

  assign asel[0]  = b0.sel;
  assign asel[1]  = b1.sel;
  assign abusy[0] = b0.busy;
  assign abusy[1] = b1.busy;
  assign ado[0]   = b0.data_out;
  assign ado[1]   = b1.data_out;
  assign adv[0]   = b0.data_valid;
  assign adv[1]   = b1.data_valid;

  // Model: frame position = edges since frame start; channel
  // k is sampled when that count reaches (k+1)*dwell.
  bit       minf[2] = '{0, 0};
  int       mt[2] = '{0, 0};
  bit [3:0] msmp[2] = '{0, 0};
  bit [3:0] mdo[2] = '{0, 0};
  bit       mdv[2] = '{0, 0};

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdv[i] = 1'b0;
      if (rst) begin
        minf[i] = 1'b0;
        mt[i]   = 0;
        msmp[i] = '0;
        mdo[i]  = '0;
      end else if (!minf[i]) begin
        if (start) begin
          minf[i] = 1'b1;
          mt[i]   = 0;
        end
      end else begin
        mt[i] = mt[i] + 1;
        if (mt[i] % dw(i) == 0) begin
          msmp[i][mt[i] / dw(i) - 1] =
            chans[mt[i] / dw(i) - 1];
        end
        if (mt[i] == 4 * dw(i)) begin
          mdo[i] = msmp[i];
          mdv[i] = 1'b1;
          mt[i]  = 0;
          if (!cont) minf[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t act=%0d exp=%0d",
               nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        chk("sel", i, int'(asel[i]),
            minf[i] ? mt[i] / dw(i) : 0);
        chk("busy", i, int'(abusy[i]), int'(minf[i]));
        chk("data_out", i, int'(ado[i]), int'(mdo[i]));
        chk("data_valid", i, int'(adv[i]), int'(mdv[i]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc=1 at entry; returns negedge index where valid shows.
  task automatic wait_dv(input int i, output int cyc);
    cyc = 1;
    while (!adv[i] && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int c;
  int np;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    chk("idle_busy", 0, int'(abusy[0]), 0);
    chk("idle_sel", 0, int'(asel[0]), 0);
    chk("rst_dout", 0, int'(ado[0]), 0);

    // single frame, DWELL=4, channels 0101
    pulse_start();
    wait_dv(0, c);
    chk("lat16", 0, c, 17);
    chk("frame", 0, int'(ado[0]), 4'b0101);
    @(negedge clk);
    chk("busy_after", 0, int'(abusy[0]), 0);
    repeat (4) @(negedge clk);

    // continuous, channels change before frame 2 ch0
    cont = 1'b1;
    pulse_start();
    wait_dv(0, c);
    chk("c_lat1", 0, c, 17);
    chk("c_frame1", 0, int'(ado[0]), 4'b0101);
    chans = 4'b1010;
    cont  = 1'b0;
    @(negedge clk);
    wait_dv(0, c);
    chk("c_gap", 0, c, 16);
    chk("c_frame2", 0, int'(ado[0]), 4'b1010);
    chans = 4'b0101;
    repeat (6) @(negedge clk);

    // start re-pulsed mid-frame and at frame end
    np = 0;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 16);
      if (adv[0]) np++;
    end
    start = 1'b0;
    chk("one_pulse", 0, np, 1);

    // reset at cycle 10 of a frame
    pulse_start();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_sel", 0, int'(asel[0]), 0);
    chk("ab_busy", 0, int'(abusy[0]), 0);
    chk("ab_dout", 0, int'(ado[0]), 0);
    np = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (adv[0]) np++;
    end
    chk("ab_nopulse", 0, np, 0);
    pulse_start();
    wait_dv(0, c);
    chk("ab_lat", 0, c, 17);
    chk("ab_frame", 0, int'(ado[0]), 4'b0101);
    repeat (4) @(negedge clk);

    // DWELL=1 instance, channels 1100
    chans = 4'b1100;
    pulse_start();
    wait_dv(1, c);
    chk("d1_lat", 1, c, 5);
    chk("d1_frame", 1, int'(ado[1]), 4'b1100);
    repeat (20) @(negedge clk);

    // start and rst on the same edge
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("sr_busy0", 0, int'(abusy[0]), 0);
    chk("sr_busy1", 1, int'(abusy[1]), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
